// File: rtl/sr_flipflop.sv
// rtl/sr_flipflop.sv - clocked SR flip-flop bank with async reset and configurable S=R=1 policy
module sr_flipflop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter int               BOTH_MODE = 0
) (
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             Clk,
    input  logic             Rst,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar
);

    localparam int MODE_HOLD   = 0;
    localparam int MODE_RESET  = 1;
    localparam int MODE_SET    = 2;
    localparam int MODE_TOGGLE = 3;

    // Reject unsupported parameterisations at elaboration time
    if (BOTH_MODE < MODE_HOLD || BOTH_MODE > MODE_TOGGLE) begin : g_bad_mode
        $error("sr_flipflop: BOTH_MODE must be 0..3");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sr_flipflop: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] q_next;

    // Per-bit next-state: hold, clear, set, or the S=R=1 policy
    always_comb begin
        q_next = Q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({S[i], R[i]})
                2'b01:   q_next[i] = 1'b0;
                2'b10:   q_next[i] = 1'b1;
                2'b11: begin
                    case (BOTH_MODE)
                        MODE_RESET:  q_next[i] = 1'b0;
                        MODE_SET:    q_next[i] = 1'b1;
                        MODE_TOGGLE: q_next[i] = ~Q[i];
                        default:     q_next[i] = Q[i];
                    endcase
                end
                default: q_next[i] = Q[i];
            endcase
        end
    end

    // State register; reset is asynchronous and overrides any clock edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Q <= RST_VAL;
        end else begin
            Q <= q_next;
        end
    end

    // Complement is derived from the register, never stored separately
    assign Q_bar = ~Q;

`ifndef SYNTHESIS
    // Unknown set/clear requests at a sampling edge would corrupt the stored bit
    a_sr_known: assert property (@(posedge Clk) disable iff (Rst) !$isunknown({S, R}));
`endif

endmodule

// File: tb/tb_sr_flipflop.sv
// tb/tb_sr_flipflop.sv - directed table-driven bench for sr_flipflop
module tb_sr_flipflop;

    logic       clk;
    logic       rst;
    logic       s1;
    logic       r1;
    logic [3:0] s4;
    logic [3:0] r4;

    logic       q0, qb0, q1, qb1, q2, qb2, q3, qb3;
    logic [3:0] q4, qb4;

    int errors = 0;
    int checks = 0;

    sr_flipflop u_hold (.S(s1), .R(r1), .Clk(clk), .Rst(rst), .Q(q0), .Q_bar(qb0));
    sr_flipflop #(.BOTH_MODE(1)) u_rdom (.S(s1), .R(r1), .Clk(clk), .Rst(rst), .Q(q1), .Q_bar(qb1));
    sr_flipflop #(.BOTH_MODE(2)) u_sdom (.S(s1), .R(r1), .Clk(clk), .Rst(rst), .Q(q2), .Q_bar(qb2));
    sr_flipflop #(.BOTH_MODE(3)) u_tog  (.S(s1), .R(r1), .Clk(clk), .Rst(rst), .Q(q3), .Q_bar(qb3));
    sr_flipflop #(.WIDTH(4), .RST_VAL(4'b1010)) u_w4 (.S(s4), .R(r4), .Clk(clk), .Rst(rst), .Q(q4), .Q_bar(qb4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic s;
        logic r;
        logic exp_q;
    } vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive S/R at the falling edge, let one rising edge pass, sample 1ns later
    task automatic step1(input logic s, input logic r);
        @(negedge clk);
        s1 = s;
        r1 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s1 = 1'b0; r1 = 1'b0; s4 = '0; r4 = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        rst = 1'b1;
        s1 = 1'b1; r1 = 1'b0; s4 = '0; r4 = '0;

        // S/R = 00, 01, 10, 11, then set/hold/clear, then hold-at-zero and re-set
        vecs[0]  = '{1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0};

        // Reset held with S=1 while clocking: Q stays at reset value
        #1;
        check("rst_async_q", {3'b0, q0}, 4'b0000);
        check("rst_async_w4", q4, 4'b1010);
        check("rst_async_w4_bar", qb4, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_held_q", {3'b0, q0}, 4'b0000);
            check("rst_held_qb", {3'b0, qb0}, 4'b0001);
        end

        @(negedge clk);
        rst = 1'b0;
        s1 = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step1(vecs[i].s, vecs[i].r);
            check($sformatf("vec%0d_q", i), {3'b0, q0}, {3'b0, vecs[i].exp_q});
            check($sformatf("vec%0d_qb", i), {3'b0, qb0}, {3'b0, ~vecs[i].exp_q});
        end

        // Async reset between edges with Q=1
        step1(1'b1, 1'b0);
        check("pre_async_q", {3'b0, q0}, 4'b0001);
        @(negedge clk);
        s1 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_mid_q", {3'b0, q0}, 4'b0000);
        check("async_mid_qb", {3'b0, qb0}, 4'b0001);
        @(negedge clk);
        rst = 1'b0;
        s1 = 1'b1;
        #1;
        check("release_no_edge_q", {3'b0, q0}, 4'b0000);
        @(posedge clk);
        #1;
        check("release_first_edge_q", {3'b0, q0}, 4'b0001);

        // Reset asserted exactly at a rising edge with S=1 wins
        do_reset();
        s1 = 1'b1;
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("rst_at_edge_q", {3'b0, q0}, 4'b0000);

        // S=R=1 mode sweep from Q=0 over two edges
        do_reset();
        step1(1'b1, 1'b1);
        check("m0_e1", {3'b0, q0}, 4'b0000);
        check("m1_e1", {3'b0, q1}, 4'b0000);
        check("m2_e1", {3'b0, q2}, 4'b0001);
        check("m3_e1", {3'b0, q3}, 4'b0001);
        step1(1'b1, 1'b1);
        check("m0_e2", {3'b0, q0}, 4'b0000);
        check("m1_e2", {3'b0, q1}, 4'b0000);
        check("m2_e2", {3'b0, q2}, 4'b0001);
        check("m3_e2", {3'b0, q3}, 4'b0000);
        check("m3_e2_bar", {3'b0, qb3}, 4'b0001);
        step1(1'b1, 1'b1);
        check("m3_e3", {3'b0, q3}, 4'b0001);

        // Multi-bit with nonzero reset value
        do_reset();
        #1;
        check("w4_reset_q", q4, 4'b1010);
        check("w4_reset_qb", qb4, 4'b0101);
        @(negedge clk);
        s4 = 4'b0001;
        r4 = 4'b1000;
        @(posedge clk);
        #1;
        check("w4_sr_q", q4, 4'b0011);
        check("w4_sr_qb", qb4, 4'b1100);
        @(negedge clk);
        s4 = 4'b1111;
        r4 = 4'b1111;
        @(posedge clk);
        #1;
        check("w4_both_hold", q4, 4'b0011);
        @(negedge clk);
        s4 = 4'b0100;
        r4 = 4'b0001;
        #2;
        s4 = 4'b0000;
        r4 = 4'b0000;
        @(posedge clk);
        #1;
        check("w4_between_edges", q4, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_flipflop.md
# sr_flipflop

Clocked set/reset flip-flop with complementary outputs, an asynchronous active-high reset, and a configurable, deterministic policy for the S=R=1 input combination. It is a leaf storage element for control flags such as sticky status bits, enable latches and request/grant holds. It is used directly by the flip-flop family benches. The default parameterisation is a single-bit SR flip-flop instantiated positionally as (S, R, Clk, Rst, Q, Q_bar).

## Interface
Parameters:
- WIDTH, 1: number of independent SR bits. Bit i uses S[i], R[i], Q[i], Q_bar[i]; bits share Clk and Rst.
- RST_VAL, all zeros: value loaded into Q by reset; WIDTH bits wide.
- BOTH_MODE, 0: action when S[i]=R[i]=1.
  - 0 = hold
  - 1 = reset-dominant (Q=0)
  - 2 = set-dominant (Q=1)
  - 3 = toggle
  - Any other value is a compile-time error.

Ports, in positional instantiation order S, R, Clk, Rst, Q, Q_bar:
- Clk  input  1  the single clock, rising-edge active.
- Rst  input  1  reset; asynchronous, active-high.
- S  input  WIDTH  set request.
- R  input  WIDTH  reset (clear) request.
- Q  output  WIDTH  registered state.
- Q_bar  output  WIDTH  bitwise complement of Q.

## Operation
- Reset: while Rst=1, Q=RST_VAL and Q_bar=~RST_VAL. Reset overrides S, R and Clk.
- At each rising Clk edge with Rst=0, each bit updates independently:
  - S=0, R=0: hold Q.
  - S=0, R=1: Q<=0.
  - S=1, R=0: Q<=1.
  - S=1, R=1: action per BOTH_MODE; the default is hold.
- Q_bar is always the exact bitwise inverse of Q, derived combinationally from the Q register. It is never independently stored and never equal to Q.
- No X propagation from legal inputs: S=R=1 never produces X on Q.
- If S or R is X/Z at a sampling edge, Q may become X. A simulation-only assertion flags this condition; the assertion is excluded from synthesis.
- Outputs are purely registered state. There is no combinational path from S or R to Q or Q_bar.

## Timing
- Latency: S/R sampled on rising edge N appear on Q after edge N, with clock-to-Q delay only.
- Rst assertion: Q goes to RST_VAL immediately, asynchronously, without waiting for a clock edge.
- Rst deassertion: the first state update occurs on the first rising Clk edge at which Rst is sampled low. That edge applies the S/R values present at the edge.
- Reset coinciding with a clock edge: reset wins, and Q=RST_VAL.
- Reset asserted mid-sequence: the stored state is lost. After release, operation resumes from RST_VAL.
- S/R changes between edges have no effect on Q.
- Toggle mode (BOTH_MODE=3) with S=R=1 held: Q alternates on every rising edge.

## Test plan
- Reset: Rst=1 with S=1, R=0 while clocking -> Q=0, Q_bar=1 throughout, and Q changes without waiting for a clock edge.
- Basic sequence: release Rst, then drive S,R=00, 01, 10, 11, each held over one rising edge (default parameters) -> Q = 0, 0, 1, 1 and Q_bar = 1, 1, 0, 0. The final step shows S=R=1 holding Q.
- Set then clear: S=1 for one edge -> Q=1. Then S=0, R=0 for 3 edges -> Q stays 1. Then R=1 for one edge -> Q=0, Q_bar=1.
- Asynchronous reset mid-operation: with Q=1, assert Rst between edges -> Q=0 before the next edge. Release Rst with S=1 -> Q=1 after the next edge.
- BOTH_MODE sweep, starting from Q=0 with S=R=1 applied for 2 edges:
  - mode 1 -> Q=0, 0
  - mode 2 -> Q=1, 1
  - mode 3 -> Q=1, 0
- Multi-bit and RST_VAL: WIDTH=4, RST_VAL=4'b1010 -> reset gives Q=1010, Q_bar=0101. Then S=0001, R=1000 -> Q=0011; other bits are unaffected.
